// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - fetch-side types, lane widths and exception helper
// Purpose: shared fetch payload types for the fetch/decode boundary.
// Contents:
//   fetch_data_t     one fetched instruction and its fetch-time fault flags
//   FETCH_PUSH_WIDTH lanes offered per cycle by fetch
//   FETCH_POP_WIDTH  lanes presented per cycle to decode
//   fetch_group_t    a pop-width group of entries plus its valid vector
//   fetch_has_exc()  true when an entry carries any exception or TLB flag
package fetch_pkg;

  localparam int FETCH_PUSH_WIDTH = 2;
  localparam int FETCH_POP_WIDTH  = 2;

  typedef struct packed {
    logic [31:0] pcplus4;
    logic [31:0] instr;
    logic        exception_instr;
    logic        i_tlb_invalid;
    logic        i_tlb_modified;
    logic        i_tlb_refill;
  } fetch_data_t;

  typedef struct packed {
    logic        [FETCH_POP_WIDTH-1:0] valid;
    fetch_data_t [FETCH_POP_WIDTH-1:0] data;
  } fetch_group_t;

  function automatic logic fetch_has_exc(input fetch_data_t e);
    return e.exception_instr | e.i_tlb_invalid | e.i_tlb_modified | e.i_tlb_refill;
  endfunction

endpackage

// File: rtl/fetch_queue_lead_ones.sv
// rtl/fetch_queue_lead_ones.sv - count of consecutive ones from bit 0 upward
// Purpose: number of leading (from lane 0) set bits of a lane vector.
// Ports:
//   bits  in  W              lane vector, bit 0 is the oldest lane
//   cnt   out clog2(W+1)     number of consecutive ones starting at bit 0
module fetch_queue_lead_ones #(
  parameter int W = 2
) (
  input  logic [W-1:0]           bits,
  output logic [$clog2(W+1)-1:0] cnt
);

  localparam int CW = $clog2(W + 1);

  logic run;

  always_comb begin
    cnt = '0;
    run = 1'b1;
    for (int i = 0; i < W; i++) begin
      run = run & bits[i];
      if (run) cnt = CW'(i + 1);
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - multi-lane fetch-to-decode instruction queue
// Purpose: circular queue of fetch_data_t entries, multi-lane push and pop,
//          with issue lanes cut after the first entry carrying a fault flag.
// Ports:
//   clk         in  1                      clock
//   reset       in  1                      asynchronous reset, active-high
//   flush       in  1                      drop all contents and same-cycle push/pop
//   push_valid  in  PUSH_WIDTH             thermometer lane valids from fetch
//   push_data   in  PUSH_WIDTH entries     lane payloads, lane 0 oldest
//   push_ready  out 1                      room for a full PUSH_WIDTH group
//   pop_valid   out POP_WIDTH              head lanes valid, lane 0 oldest
//   pop_data    out POP_WIDTH entries      head entries
//   pop_count   in  clog2(POP_WIDTH+1)     leading lanes consumed this cycle
//   count       out clog2(DEPTH+1)         current occupancy
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int PUSH_WIDTH = FETCH_PUSH_WIDTH,
  parameter int POP_WIDTH  = FETCH_POP_WIDTH
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               flush,
  input  logic        [PUSH_WIDTH-1:0]       push_valid,
  input  fetch_data_t [PUSH_WIDTH-1:0]       push_data,
  output logic                               push_ready,
  output logic        [POP_WIDTH-1:0]        pop_valid,
  output fetch_data_t [POP_WIDTH-1:0]        pop_data,
  input  logic        [$clog2(POP_WIDTH+1)-1:0] pop_count,
  output logic        [$clog2(DEPTH+1)-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PU_W  = $clog2(PUSH_WIDTH + 1);
  localparam int PO_W  = $clog2(POP_WIDTH + 1);

  fetch_data_t mem [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  logic [PU_W-1:0]  push_lead;
  logic [PU_W-1:0]  npush;
  logic [PO_W-1:0]  pop_avail;
  logic [PO_W-1:0]  npop;
  logic             blocked;

  // Ready looks only at current occupancy; a same-cycle pop earns no credit.
  assign push_ready = (count <= CNT_W'(DEPTH - PUSH_WIDTH));

  fetch_queue_lead_ones #(.W(PUSH_WIDTH)) u_push_lead (
    .bits (push_valid),
    .cnt  (push_lead)
  );

  // Only the leading ones of push_valid are taken, so a malformed vector
  // such as 2'b10 pushes nothing.
  assign npush = (push_ready && !flush) ? push_lead : '0;

  // Head lanes: a lane is offered only if it holds data and no older lane
  // in the group carries a fault, so a faulting entry always closes its group.
  always_comb begin
    blocked = 1'b0;
    for (int i = 0; i < POP_WIDTH; i++) begin
      pop_data[i]  = mem[head + PTR_W'(i)];
      pop_valid[i] = (count > CNT_W'(i)) && !blocked;
      if (fetch_has_exc(pop_data[i])) blocked = 1'b1;
    end
  end

  fetch_queue_lead_ones #(.W(POP_WIDTH)) u_pop_lead (
    .bits (pop_valid),
    .cnt  (pop_avail)
  );

  // Over-asking is clamped to what is actually offered.
  assign npop = (pop_count < pop_avail) ? pop_count : pop_avail;

  // Storage is not reset; pointers and count alone define validity.
  always_ff @(posedge clk) begin
    for (int i = 0; i < PUSH_WIDTH; i++) begin
      if (PU_W'(i) < npush) mem[tail + PTR_W'(i)] <= push_data[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(npop);
      tail  <= tail + PTR_W'(npush);
      count <= count + CNT_W'(npush) - CNT_W'(npop);
    end
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Parametrised multi-lane instruction queue between the fetch stage and decode. Holds fetch_data_t entries. Accepts up to PUSH_WIDTH entries per cycle and presents up to POP_WIDTH head entries per cycle. Supports flush. Masks issue lanes so that an entry carrying any exception/TLB flag is always the last entry presented in its group.

Parameters:
DEPTH, 8, number of entries; power of two, >= 2*max(PUSH_WIDTH, POP_WIDTH)
PUSH_WIDTH, 2, entries offered per cycle by fetch
POP_WIDTH, 2, entries presented per cycle to decode

Ports:
clk  in  1  clock
reset  in  1  asynchronous reset, active-high
flush  in  1  discard all contents and any same-cycle push
push_valid  in  PUSH_WIDTH  lane valids; must be thermometer-coded (lane i valid implies lanes <i valid)
push_data  in  PUSH_WIDTH x fetch_data_t  lane payloads; lane 0 is oldest
push_ready  out  1  queue can take a full PUSH_WIDTH group this cycle
pop_valid  out  POP_WIDTH  head lanes valid; lane 0 is oldest
pop_data  out  POP_WIDTH x fetch_data_t  head entries
pop_count  in  $clog2(POP_WIDTH+1)  number of leading lanes consumed this cycle
count  out  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Storage: DEPTH-entry circular array, head/tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus a count register.
- Reset, asynchronous: head=0, tail=0, count=0. Outputs after reset: pop_valid=0, push_ready=1, count=0. Array contents are not reset. pop_data is don't-care while its lane is invalid.
- push_ready = (DEPTH - count) >= PUSH_WIDTH. It is combinational from count only and takes no credit for a same-cycle pop.
- Push handshake: npush = number of leading ones in push_valid when push_ready=1 and flush=0; otherwise npush=0. Lane i writes mem[tail+i]. tail += npush.
- A non-thermometer push_valid is illegal. Behaviour is defined anyway: only the leading ones are pushed.
- Raw lane availability: raw[i] = (count > i).
- Exception flag: exc(e) = e.exception_instr | e.i_tlb_invalid | e.i_tlb_modified | e.i_tlb_refill.
- Lane masking: pop_valid[i] = raw[i] and no lane j<i has exc(pop_data[j]). An exceptional entry is therefore always the last valid lane.
- pop_data[i] = mem[head+i], read combinationally with no bypass. An entry pushed in cycle t is first visible in cycle t+1 (minimum latency 1).
- Pop: npop = min(pop_count, number of asserted pop_valid). Requesting more is illegal and is clamped, never underflows. head += npop.
- Occupancy update: count_next = count + npush - npop. A simultaneous push and pop in the same cycle is legal.
- Flush (synchronous, highest priority): head=0, tail=0, count=0 next cycle. Same-cycle push and pop are ignored.
- Reset asserted mid-operation behaves as flush, immediately and asynchronously.
- Full: count > DEPTH-PUSH_WIDTH drops push_ready. The queue never overflows.
- Empty: all pop_valid=0. pop_count is ignored.
- Wrap-around: reads and writes that straddle index DEPTH-1 → 0 are contiguous modulo DEPTH.

Decomposition:
- fetch_pkg gains:
  - FETCH_PUSH_WIDTH and FETCH_POP_WIDTH constants
  - fetch_group_t typedef (array of fetch_data_t plus valid vector)
  - function fetch_has_exc(fetch_data_t) implementing exc()
- Sub-module fetch_queue_lead_ones (parametrised leading-ones counter). It is used for npush and for the masked pop_valid count.
- Everything else stays in fetch_queue.

Test Plan:
- Reset, then push 2 entries (pcplus4 = 0x4, 0x8) with pop_count=0 → next cycle count=2, pop_valid=2'b11, pop_data[0].pcplus4=0x4, pop_data[1].pcplus4=0x8.
- Fill DEPTH=8 with pop_count=0 → push_ready=0 when count=7 and when count=8. Further push_valid=2'b11 leaves count=8 and the contents unchanged.
- Steady stream: push 2 and pop 2 every cycle for 20 cycles, pcplus4 incrementing by 4 → popped sequence strictly in order across pointer wrap, count constant at 2.
- Entry 0 with i_tlb_refill=1 and entry 1 clean at head → pop_valid=2'b01. After pop_count=1, the clean entry is presented with pop_valid[0]=1.
- Count=5 with flush=1 and push_valid=2'b11 in the same cycle → next cycle count=0, pop_valid=0, push_ready=1.
- Push_valid=2'b10 (illegal) with count=0 → nothing pushed, count stays 0. Reset pulsed mid-stream → count=0 immediately.
